fft_frame_sched: RTL
====================

Name: fft_frame_sched

Overview:
Sequencing controller for the 8-point parallel FFT core (write/start/ready interface, 16-bit signed complex I/O).
- Accepts a serial stream of complex samples and gathers 8 into a frame.
- Loads the frame into the core with a write pulse, then holds start for the core's pipeline depth.
- Captures the 8 results and streams them out serially with valid/ready.
- Sits between the sample source/sink and the core, and owns every core control pin.

Parameters:
DATA_W, 16, width of each real/imag component
CORE_LAT, 3, consecutive start cycles the core needs to flush its pipeline
CNT_W, 16, width of the completed-frame counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_real  in  DATA_W  input real part, signed
s_imag  in  DATA_W  input imag part, signed
m_valid  out  1  output sample valid
m_ready  in  1  sink accepts output
m_real  out  DATA_W  output real part
m_imag  out  DATA_W  output imag part
m_index  out  3  bin index k of X[k]
m_last  out  1  high with index 7
fft_write  out  1  to core write
fft_start  out  1  to core start
fft_in  out  16*DATA_W  frame to core; sample k at [k*2*DATA_W +: 2*DATA_W], real in the low half
fft_ready  in  1  from core ready
fft_out  in  16*DATA_W  core results, same packing as fft_in
frame_cnt  out  CNT_W  completed frames, wraps
err  out  1  sticky error: fft_ready low at capture

Behaviour:
- Reset (RST=1 at a CLK edge): state=FILL; in_cnt=0; out_idx=0; m_valid=0; fft_write=0; fft_start=0; frame_cnt=0; err=0. Buffer contents are don't-care.
- Reset is honoured in every state, including mid-RUN and mid-DRAIN. fft_start is low in the cycle after the reset edge, and the partial frame is discarded.
- States: FILL, LOAD, RUN, CAPTURE, DRAIN.
- FILL: s_ready=1. On s_valid&s_ready, write the sample into in_buf[in_cnt] and increment in_cnt. When the 8th sample is accepted, go to LOAD.
- LOAD (1 cycle): fft_write=1, fft_start=0, fft_in=in_buf, s_ready=0. Clear in_cnt; go to RUN with run_cnt=0.
- RUN: fft_start=1, fft_write=0, for exactly CORE_LAT cycles. Then go to CAPTURE.
- CAPTURE (1 cycle): fft_start=0. Latch fft_out into out_buf. If fft_ready=0, set err. Go to DRAIN with out_idx=0.
- DRAIN: m_valid=1, m_real/m_imag=out_buf[out_idx], m_index=out_idx, m_last=(out_idx==7).
  - On m_valid&m_ready, increment out_idx.
  - On the handshake at index 7, increment frame_cnt (wrapping) and go to FILL.
  - Outputs hold stable while m_ready=0.
- fft_in is driven from in_buf at all times. The core only samples it during LOAD.
- Latency: the 8th input handshake edge is followed by the first m_valid after exactly 2+CORE_LAT cycles (5 at default).
- No arithmetic in this block. Samples pass bit-exact.
- m_real/m_imag/m_index are don't-care while m_valid=0.

Optional Feature:
FFT_SCHED_OVERLAP_EN
- Defined:
  - s_ready = (in_cnt<8) in FILL, RUN, CAPTURE and DRAIN; s_ready=0 in LOAD, so the next frame fills while the current one computes and drains.
  - FILL with in_cnt==8 goes to LOAD.
  - The final DRAIN handshake goes to LOAD directly if in_cnt==8, otherwise to FILL.
- Undefined: s_ready=1 only in FILL; all other states as above.

Decomposition:
- Package fft_sched_pkg holds:
  - state enum (FILL, LOAD, RUN, CAPTURE, DRAIN)
  - N_POINTS=8, IDX_W=3
  - complex-sample pack/unpack functions for the fft_in/fft_out bit layout
- One sub-module: fft_frame_buf, an 8-entry serial-write/parallel-read complex register, used for in_buf.
- out_buf is a parallel-load register with an indexed read, kept inline.

Test Plan:
- Streaming: samples k+1 (real) and -k (imag) for k=0..7, m_ready=1, core model with CORE_LAT=3 → exactly one fft_write pulse, then 3 fft_start cycles; first m_valid 5 cycles after the 8th handshake; m_index 0..7 with m_last on index 7; frame_cnt=1; err=0.
- Backpressure: hold m_ready=0 for 4 cycles at index 3 → m_real/m_imag/m_index stable throughout; no sample lost or duplicated.
- Faulty core: model keeps fft_ready=0 → err=1 after CAPTURE and stays 1 until RST.
- Reset mid-RUN: RST pulse on the 2nd start cycle → fft_start=0 and m_valid=0 next cycle; state FILL; frame_cnt=0; the next full frame processes correctly.
- Overlap, with FFT_SCHED_OVERLAP_EN: send 16 samples back-to-back → second frame accepted during DRAIN; DRAIN goes straight to LOAD; frame_cnt=2.
- Overlap, without the macro: same 16 samples → s_ready=0 from LOAD through DRAIN.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared states, sizes and bit-layout helpers for the FFT frame sequencer
package fft_sched_pkg;
  typedef enum logic [2:0] {FILL, LOAD, RUN, CAPTURE, DRAIN} state_t;
  localparam int N_POINTS = 8;
  localparam int IDX_W = 3;
  function automatic int cplx_re_lsb(input int k, input int w);
    return 2 * k * w;
  endfunction
  function automatic int cplx_im_lsb(input int k, input int w);
    return 2 * k * w + w;
  endfunction
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: 8-entry complex register, serial write by index, whole frame read in parallel
module fft_frame_buf
  import fft_sched_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]              wr_real,
  input  logic [DATA_W-1:0]              wr_imag,
  output logic [2*N_POINTS*DATA_W-1:0]   rd_bus
);
  always_ff @(posedge clk)
    for (int k = 0; k < N_POINTS; k++)
      if (wr_en && wr_idx == IDX_W'(k)) begin
        rd_bus[cplx_re_lsb(k, DATA_W) +: DATA_W] <= wr_real;
        rd_bus[cplx_im_lsb(k, DATA_W) +: DATA_W] <= wr_imag;
      end
endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: gathers 8 samples, runs the FFT core, streams results out
// FFT_SCHED_OVERLAP_EN lets the next frame fill while the current one computes and drains
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CORE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_real,
  input  logic [DATA_W-1:0]    s_imag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_real,
  output logic [DATA_W-1:0]    m_imag,
  output logic [IDX_W-1:0]     m_index,
  output logic                 m_last,
  output logic                 fft_write,
  output logic                 fft_start,
  output logic [16*DATA_W-1:0] fft_in,
  input  logic                 fft_ready,
  input  logic [16*DATA_W-1:0] fft_out,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 err
);
  localparam int RUN_W = CORE_LAT > 1 ? $clog2(CORE_LAT) : 1;
  state_t state, next;
  logic [IDX_W:0] in_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [IDX_W-1:0] out_idx;
  logic [16*DATA_W-1:0] out_buf;
  logic acc, m_acc, last_hs, in_full, frame_done, run_done;
  assign in_full = in_cnt == (IDX_W+1)'(N_POINTS);
`ifdef FFT_SCHED_OVERLAP_EN
  assign s_ready = state != LOAD && !in_full;
`else
  assign s_ready = state == FILL;
`endif
  assign acc        = s_valid && s_ready;
  assign frame_done = (acc && in_cnt == (IDX_W+1)'(N_POINTS - 1)) || in_full;
  assign run_done   = run_cnt == RUN_W'(CORE_LAT - 1);
  assign m_valid    = state == DRAIN;
  assign m_acc      = m_valid && m_ready;
  assign last_hs    = m_acc && out_idx == IDX_W'(N_POINTS - 1);
  assign m_last     = m_valid && out_idx == IDX_W'(N_POINTS - 1);
  assign m_index    = out_idx;
  assign m_real     = out_buf[cplx_re_lsb(int'(out_idx), DATA_W) +: DATA_W];
  assign m_imag     = out_buf[cplx_im_lsb(int'(out_idx), DATA_W) +: DATA_W];
  assign fft_write  = state == LOAD;
  assign fft_start  = state == RUN;
  fft_frame_buf #(.DATA_W(DATA_W)) u_in_buf (
    .clk    (CLK),
    .wr_en  (acc),
    .wr_idx (in_cnt[IDX_W-1:0]),
    .wr_real(s_real),
    .wr_imag(s_imag),
    .rd_bus (fft_in)
  );
  always_ff @(posedge CLK) state <= RST ? FILL : next;
  always_comb begin
    next = state;
    case (state)
      FILL:    next = frame_done ? LOAD : FILL;
      LOAD:    next = RUN;
      RUN:     next = run_done ? CAPTURE : RUN;
      CAPTURE: next = DRAIN;
      DRAIN:   next = !last_hs ? DRAIN : in_full ? LOAD : FILL;
      default: next = FILL;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      in_cnt    <= '0;
      run_cnt   <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      in_cnt    <= state == LOAD ? '0 : in_cnt + (IDX_W+1)'(acc);
      run_cnt   <= state == RUN ? run_cnt + RUN_W'(1) : '0;
      out_idx   <= state == CAPTURE ? '0 : out_idx + IDX_W'(m_acc);
      frame_cnt <= frame_cnt + CNT_W'(last_hs);
      err       <= err || (state == CAPTURE && !fft_ready);
    end
  always_ff @(posedge CLK)
    if (state == CAPTURE) out_buf <= fft_out;
endmodule
